// File: rtl/jt49_envelope.sv
// Envelope generator for the jt49 PSG: walks a level ramp on each step tick
// according to the latched {CONT, ATT, ALT, HOLD} shape bits.
module jt49_envelope #(
  parameter int unsigned ENV_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             step,
  input  logic [3:0]       ctrl,
  input  logic             restart,
  output logic [ENV_W-1:0] env,
  output logic             stopped
);

  localparam logic [ENV_W-1:0] MaxCnt = '1;

  logic [ENV_W-1:0] cnt_q, cnt_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             inv_q, inv_d;
  logic             stop_q, stop_d;
  logic             zero_q, zero_d;
  logic             step_l_q, step_l_d;
  logic             adv;

  wire cont = ctrl_q[3];
  wire alt  = ctrl_q[1];
  wire hold = ctrl_q[0];

  always_comb begin
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    inv_d    = inv_q;
    stop_d   = stop_q;
    zero_d   = zero_q;
    // The edge detector only samples on enabled cycles, so an edge seen
    // while cen is low stays pending until the next enabled cycle.
    step_l_d = cen ? step : step_l_q;
    adv      = cen & step & ~step_l_q;

    if (restart) begin
      // Restart swallows any coincident step edge.
      ctrl_d = ctrl;
      cnt_d  = '0;
      inv_d  = ~ctrl[2];
      stop_d = 1'b0;
      zero_d = 1'b0;
    end else if (adv && !stop_q) begin
      if (cnt_q != MaxCnt) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!cont) begin
        stop_d = 1'b1;
        zero_d = 1'b1;
      end else if (hold) begin
        stop_d = 1'b1;
        inv_d  = inv_q ^ alt;
      end else begin
        cnt_d = '0;
        inv_d = inv_q ^ alt;
      end
    end

    env_d = zero_d ? '0 : (cnt_d ^ {ENV_W{inv_d}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ctrl_q   <= '0;
      inv_q    <= 1'b0;
      stop_q   <= 1'b1;
      zero_q   <= 1'b1;
      step_l_q <= 1'b0;
      env_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      inv_q    <= inv_d;
      stop_q   <= stop_d;
      zero_q   <= zero_d;
      step_l_q <= step_l_d;
      env_q    <= env_d;
    end
  end

  assign env     = env_q;
  assign stopped = stop_q;

endmodule

// File: tb/tb_jt49_envelope.sv
// Self-checking bench for jt49_envelope: randomized step/cen timing checked
// against a shape model indexed by the number of steps since restart.
module tb_jt49_envelope;

  localparam int W    = 5;
  localparam int NSTP = 32;
  localparam int MAXV = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic         step;
  logic [3:0]   ctrl;
  logic         restart;
  logic [W-1:0] env;
  logic         stopped;

  int checks = 0;
  int errors = 0;

  // Model state: latched shape, steps since restart, waiting-after-reset flag.
  logic [3:0] m_shape = 4'h0;
  int         m_k     = 0;
  logic       m_rstd  = 1'b1;

  jt49_envelope #(.ENV_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .step    (step),
    .ctrl    (ctrl),
    .restart (restart),
    .env     (env),
    .stopped (stopped)
  );

  always #5 clk = ~clk;

  function automatic int exp_env(logic [3:0] sh, int k, logic rstd);
    int  r;
    int  p;
    logic rising;
    if (rstd) return 0;
    r = k / NSTP;
    p = k % NSTP;
    if (r == 0) return sh[2] ? p : MAXV - p;
    if (!sh[3]) return 0;
    if (sh[0]) return (sh[2] ^ sh[1]) ? MAXV : 0;
    rising = sh[2] ^ (sh[1] & r[0]);
    return rising ? p : MAXV - p;
  endfunction

  function automatic int exp_stop(logic [3:0] sh, int k, logic rstd);
    if (rstd) return 1;
    return (k >= NSTP && (!sh[3] || sh[0])) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".env"}, int'(env), exp_env(m_shape, m_k, m_rstd));
    check({tag, ".stopped"}, int'(stopped), exp_stop(m_shape, m_k, m_rstd));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One step rising edge with randomized cen gaps; leaves step low.
  task automatic give_step(input string tag);
    int n;
    step = 1'b1;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin cen = 1'b0; cyc(); end
    cen = 1'b1; cyc();
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin cen = 1'($urandom_range(0, 1)); cyc(); end
    step = 1'b0;
    cen = 1'b1; cyc();
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin cen = 1'($urandom_range(0, 1)); cyc(); end
    if (!m_rstd) m_k++;
    check_model(tag);
  endtask

  task automatic do_restart(input logic [3:0] sh, input string tag);
    ctrl    = sh;
    step    = 1'b0;
    cen     = 1'($urandom_range(0, 1));
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    ctrl    = 4'($urandom);
    m_shape = sh;
    m_k     = 0;
    m_rstd  = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [3:0] sh;
    int         n;

    rst = 1'b1; cen = 1'b0; step = 1'b0; ctrl = 4'h0; restart = 1'b0;
    repeat (2) cyc();
    check_model("reset_held");
    rst = 1'b0;
    cyc();
    check_model("reset_released");
    give_step("idle_after_reset");

    // Rise then hold 31.
    do_restart(4'hD, "d_restart");
    for (int i = 0; i < 36; i++) give_step("shape_d");

    // One-shot fall then 0.
    do_restart(4'h0, "0_restart");
    for (int i = 0; i < 34; i++) give_step("shape_0");

    // Triangle starting low over 96 edges.
    do_restart(4'hE, "e_restart");
    for (int i = 0; i < 96; i++) give_step("shape_e");

    do_restart(4'hB, "b_restart");
    for (int i = 0; i < 34; i++) give_step("shape_b");
    do_restart(4'hF, "f_restart");
    for (int i = 0; i < 34; i++) give_step("shape_f");

    // Random shapes and run lengths.
    for (int j = 0; j < 6; j++) begin
      sh = 4'($urandom);
      do_restart(sh, "rand_restart");
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) give_step("rand_shape");
    end

    // Restart coincident with a step edge at level 17.
    do_restart(4'hC, "c_restart");
    for (int i = 0; i < 17; i++) give_step("c_ramp");
    check("c_at_17", int'(env), 17);
    ctrl = 4'hC; step = 1'b1; cen = 1'b1; restart = 1'b1;
    cyc();
    restart = 1'b0;
    m_shape = 4'hC; m_k = 0;
    check("collide_env", int'(env), 0);
    check("collide_stopped", int'(stopped), 0);
    repeat (3) cyc();
    check("step_held_high", int'(env), 0);
    step = 1'b0; cyc();
    give_step("after_collide");

    // ctrl change without restart must be ignored.
    ctrl = 4'h0;
    for (int i = 0; i < 33; i++) give_step("ctrl_ignored");

    // Asynchronous reset between clock edges, mid-ramp.
    do_restart(4'hC, "c2_restart");
    for (int i = 0; i < 9; i++) give_step("c2_ramp");
    #2 rst = 1'b1;
    #1;
    m_rstd = 1'b1;
    check_model("async_reset");
    cyc();
    #2 rst = 1'b0;
    cyc();
    give_step("wait_restart");

    // Pending step edge held through cen=0.
    do_restart(4'hC, "c3_restart");
    step = 1'b1; cen = 1'b0;
    repeat (10) cyc();
    check("pending_no_adv", int'(env), 0);
    cen = 1'b1;
    repeat (3) cyc();
    step = 1'b0; cyc();
    m_k = 1;
    check_model("pending_one_adv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_envelope.md
# jt49_envelope

AY-3-8910/YM2149 envelope generator for the jt49 PSG core. It sits directly downstream of the `jt49_div` envelope-period divider and consumes that divider's `div` output as its step tick. It walks a 5-bit level ramp according to the 4-bit shape register and produces the envelope level that feeds the channel amplitude mux.

## Interface
- `ENV_W`, default 5: envelope level width; one ramp is 2**ENV_W steps.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cen` in 1: clock enable, shared with `jt49_div`; qualifies step-edge detection only.
- `step` in 1: `div` output of the envelope-period `jt49_div`; each cen-qualified rising edge advances the envelope one step.
- `ctrl` in 4: shape bits `{CONT, ATT, ALT, HOLD}` (bit 3 to bit 0).
- `restart` in 1: single-cycle pulse on a CPU write to the shape register; latches `ctrl` and restarts the envelope. Acts regardless of `cen`.
- `env` out ENV_W: current envelope level, registered.
- `stopped` out 1: high while the envelope is frozen (hold or end of a one-shot).

## Operation
- State: `cnt` (ENV_W), `inv`, `stop`, `zero`, `ctrl_r` (4), `step_l`.
- Output: `env = zero ? 0 : (cnt ^ {ENV_W{inv}})`. `stopped = stop`.
- Edge: `adv = cen & step & ~step_l`. `step_l <= step` only on cycles with `cen`=1.
- Restart (highest priority):
  - `ctrl_r <= ctrl`, `cnt <= 0`, `inv <= ~ctrl[2]`, `stop <= 0`, `zero <= 0`.
  - `step_l` is not touched.
  - ATT=1 gives a rising ramp from 0. ATT=0 gives a falling ramp from max.
- Advance (`adv` & ~`stop` & ~`restart`):
  - If `cnt != max`: `cnt <= cnt + 1`.
  - If `cnt == max` (end of ramp):
    - CONT=0: `stop <= 1`, `zero <= 1`; output holds 0.
    - CONT=1, HOLD=1: `stop <= 1`; `inv` toggles if ALT=1. The level freezes at the resulting end value.
    - CONT=1, HOLD=0: `cnt <= 0` (wrap); `inv` toggles if ALT=1 (triangle), else sawtooth repeats.
- Required shape results (ENV_W=5):
  - Shapes 0–7: one ramp, then 0.
  - 8: repeating falling sawtooth.
  - 9: fall, then hold 0.
  - 10: triangle starting high.
  - 11: fall, then hold 31.
  - 12: repeating rising sawtooth.
  - 13: rise, then hold 31.
  - 14: triangle starting low.
  - 15: rise, then hold 0.
- `ctrl` changes without `restart` are ignored. Only `ctrl_r` steers behaviour.
- While `stop`=1, `adv` has no effect; only `restart` or `rst` leaves the stopped state.

## Timing
- Reset values: `cnt`=0, `inv`=0, `stop`=1, `zero`=1, `ctrl_r`=0, `step_l`=0. So `env`=0 and `stopped`=1.
- Reset is asynchronous. Asserting it mid-ramp forces `env`=0 and `stopped`=1 immediately. After release, the block waits for `restart`.
- Advance latency: `env` takes its new value on the clk edge where `adv`=1, so it is visible in the following cycle. Exactly one step per `step` rising edge.
- `step` high across several cen cycles produces one advance only. With `cen`=0, a `step` edge is held pending in `step_l` until the next `cen`=1 cycle.
- Restart latency: the new start level (0 or max) is visible on `env` one clk after `restart`=1. `stopped` falls on the same edge.
- Simultaneous `restart` and `adv`: restart wins and the step is discarded. The next advance needs a fresh rising edge of `step`.
- Wrap-around in a repeating shape takes a single step: max → 0 for a sawtooth, max → max for a triangle (`inv` flips). No extra idle step is inserted.
- `cnt` arithmetic is modulo 2**ENV_W; increment occurs only below max.

## Test plan
- Reset then `restart` with `ctrl`=4'hD and step toggling every 4 cen cycles: `env` goes 0,1,…,31 one per step edge, then holds 31 with `stopped`=1. Further step edges cause no change.
- `ctrl`=4'h0: `env` starts at 31, falls to 0 over 31 steps, then `stopped`=1 and `env`=0 permanently. The 32nd edge keeps 0.
- `ctrl`=4'hE over 96 step edges: rises 0→31, then 31→0, then 0→31. Each peak and trough appears for exactly two consecutive steps; `stopped` stays 0.
- `ctrl`=4'hB: falls 31→0, then on the next edge jumps to 31 and holds; `stopped`=1. `ctrl`=4'hF: rises 0→31, then drops to 0 and holds.
- Assert `restart` in the same cycle as a step rising edge mid-ramp at `env`=17 with `ctrl`=4'hC: next-cycle `env`=0 and the edge is not counted. Change `ctrl` without `restart` and confirm there is no effect.
- Assert `rst` asynchronously mid-ramp between clk edges: `env`=0 and `stopped`=1 without waiting for clk. Hold `step`=1 with `cen`=0 for 10 cycles, then `cen`=1: exactly one advance.
